// File: rtl/dk3_audio_out.sv
// Audio output conditioning: post-reset silence, linear gain fade in/out,
// leaky-average DC removal and signed 16-bit saturation.
module dk3_audio_out #(
  parameter int unsigned MUTE_CYCLES = 2097151,
  parameter int unsigned DC_SHIFT    = 10
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ce_sample,
  input  logic signed [15:0] sample_in,
  input  logic               mute_req,
  output logic signed [15:0] audio_out,
  output logic               audio_valid,
  output logic               muted
);

  typedef enum logic [2:0] {
    S_MUTE,
    S_RAMP_UP,
    S_RUN,
    S_RAMP_DOWN,
    S_HOLD
  } state_t;

  localparam logic [8:0] GAIN_MAX = 9'd256;

  state_t             state_q, state_d;
  logic        [31:0] cnt_q, cnt_d;
  logic        [8:0]  gain_q, gain_d;
  logic signed [31:0] acc_q, acc_d;
  logic signed [16:0] diff_q, diff_d;
  logic        [8:0]  gs_q;
  logic               v1_q;
  logic signed [15:0] out_q, out_d;
  logic               valid_q;
  logic signed [25:0] prod;
  logic signed [25:0] shifted;

  // A direction change of mute_req only retargets the ramp on that edge;
  // the gain continues from its current value on the following strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gain_d  = gain_q;
    case (state_q)
      S_MUTE: begin
        gain_d = '0;
        if (cnt_q <= 32'd1) begin
          cnt_d   = '0;
          state_d = mute_req ? S_HOLD : S_RAMP_UP;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_RAMP_UP: begin
        if (mute_req) begin
          state_d = S_RAMP_DOWN;
        end else if (ce_sample) begin
          if (gain_q >= GAIN_MAX - 9'd1) begin
            gain_d  = GAIN_MAX;
            state_d = S_RUN;
          end else begin
            gain_d = gain_q + 9'd1;
          end
        end
      end
      S_RUN: begin
        gain_d = GAIN_MAX;
        if (mute_req) state_d = S_RAMP_DOWN;
      end
      S_RAMP_DOWN: begin
        if (!mute_req) begin
          state_d = S_RAMP_UP;
        end else if (ce_sample) begin
          if (gain_q <= 9'd1) begin
            gain_d  = '0;
            state_d = S_HOLD;
          end else begin
            gain_d = gain_q - 9'd1;
          end
        end
      end
      S_HOLD: begin
        gain_d = '0;
        if (!mute_req) state_d = S_RAMP_UP;
      end
      default: begin
        state_d = S_MUTE;
        gain_d  = '0;
      end
    endcase
  end

  always_comb begin
    diff_d  = 17'(32'(sample_in) - (acc_q >>> DC_SHIFT));
    acc_d   = acc_q + 32'(diff_d);
    prod    = 26'(diff_q) * $signed(26'(gs_q));
    shifted = prod >>> 8;
    if (shifted > 26'sd32767) begin
      out_d = 16'sh7fff;
    end else if (shifted < -26'sd32768) begin
      out_d = 16'sh8000;
    end else begin
      out_d = shifted[15:0];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_MUTE;
      cnt_q   <= 32'(MUTE_CYCLES);
      gain_q  <= '0;
      acc_q   <= '0;
      diff_q  <= '0;
      gs_q    <= '0;
      v1_q    <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gain_q  <= gain_d;
      if (ce_sample) begin
        acc_q  <= acc_d;
        diff_q <= diff_d;
        gs_q   <= gain_q;
      end
      v1_q    <= ce_sample;
      valid_q <= v1_q;
      if (v1_q) out_q <= out_d;
    end
  end

  assign audio_out   = out_q;
  assign audio_valid = valid_q;
  assign muted       = (gain_q == '0);

endmodule

// File: tb/tb_dk3_audio_out.sv
// Self-checking bench for dk3_audio_out: per-cycle comparison against a
// behavioural model, a vector table for DC removal, and directed corner cases.
module tb_dk3_audio_out;

  localparam int unsigned MC = 16;
  localparam int unsigned DS = 4;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic               reset, ce_sample, mute_req;
  logic signed [15:0] sample_in, audio_out;
  logic               audio_valid, muted;

  logic               s_reset, s_ce, s_mute;
  logic signed [15:0] s_sample, s_out;
  logic               s_valid, s_muted;

  dk3_audio_out #(.MUTE_CYCLES(MC), .DC_SHIFT(DS)) u_dut (
    .clk_sys(clk_sys), .reset(reset), .ce_sample(ce_sample),
    .sample_in(sample_in), .mute_req(mute_req),
    .audio_out(audio_out), .audio_valid(audio_valid), .muted(muted)
  );

  dk3_audio_out #(.MUTE_CYCLES(MC), .DC_SHIFT(10)) u_sat (
    .clk_sys(clk_sys), .reset(s_reset), .ce_sample(s_ce),
    .sample_in(s_sample), .mute_req(s_mute),
    .audio_out(s_out), .audio_valid(s_valid), .muted(s_muted)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  int     m_silent;
  int     m_gain;
  bit     m_mprev;
  longint m_acc;
  bit     p_v;
  int     p_val;
  bit     e_valid;
  int     e_out;

  typedef struct {
    int sample;
    int exp_out;
  } vec_t;
  vec_t dc_tab[5];

  function automatic longint fdiv(input longint a, input longint d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Silence for MC edges after reset; afterwards each strobe moves the gain
  // one step toward the target set by mute_req, provided mute_req has not
  // just changed. Output = clamp(floor((x - floor(acc/2^DS)) * gain / 256)).
  task automatic model_edge(input bit r, input bit ce, input int s, input bit m);
    longint avg, diff, q;
    if (r) begin
      m_silent = MC;
      m_gain   = 0;
      m_acc    = 0;
      p_v      = 0;
      p_val    = 0;
      e_valid  = 0;
      e_out    = 0;
      m_mprev  = m;
      return;
    end
    e_valid = p_v;
    if (p_v) e_out = p_val;
    if (ce) begin
      avg   = fdiv(m_acc, longint'(1) << DS);
      diff  = longint'(s) - avg;
      m_acc = m_acc + diff;
      q     = fdiv(diff * m_gain, 256);
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      p_val = int'(q);
      p_v   = 1;
    end else begin
      p_v = 0;
    end
    if (m_silent > 0) begin
      m_silent--;
    end else if (ce && (m == m_mprev)) begin
      if (m) m_gain = (m_gain > 0) ? m_gain - 1 : 0;
      else   m_gain = (m_gain < 256) ? m_gain + 1 : 256;
    end
    m_mprev = m;
  endtask

  task automatic cyc(input bit r, input bit ce, input int s, input bit m);
    reset     = r;
    ce_sample = ce;
    sample_in = 16'(s);
    mute_req  = m;
    @(posedge clk_sys);
    model_edge(r, ce, s, m);
    #1;
    chk("valid", int'(audio_valid), int'(e_valid));
    chk("out", int'(audio_out), e_out);
    chk("muted", int'(muted), (m_gain == 0) ? 1 : 0);
  endtask

  task automatic strobes(input int n, input int spacing, input int s, input bit m);
    for (int i = 0; i < n; i++) begin
      cyc(0, 1, s, m);
      for (int j = 1; j < spacing; j++) cyc(0, 0, s, m);
    end
  endtask

  task automatic zeros_to_run();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < int'(MC); i++) cyc(0, 0, 0, 0);
    strobes(258, 2, 0, 0);
  endtask

  task automatic sat_cyc(input bit r, input bit ce, input int s);
    s_reset  = r;
    s_ce     = ce;
    s_sample = 16'(s);
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    int n, viol, first_small, prev, cur;
    reset = 1; ce_sample = 0; sample_in = 0; mute_req = 0;
    s_reset = 1; s_ce = 0; s_sample = 0; s_mute = 0;

    dc_tab[0] = '{16384, 16384};
    dc_tab[1] = '{16384, 15360};
    dc_tab[2] = '{16384, 14400};
    dc_tab[3] = '{16384, 13500};
    dc_tab[4] = '{16384, 12657};

    // Reset state and startup silence with +/-1000 input every 4 cycles
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("reset_out", int'(audio_out), 0);
    chk("reset_valid", int'(audio_valid), 0);
    chk("reset_muted", int'(muted), 1);
    for (int i = 0; i < 300 * 4; i++) begin
      cyc(0, (i % 4) == 0, ((i / 4) % 2 == 0) ? 1000 : -1000, 0);
      if (i < int'(MC)) begin
        chk("startup_silent_out", int'(audio_out), 0);
        chk("startup_silent_muted", int'(muted), 1);
      end
      if (i == int'(MC)) chk("startup_first_step", int'(muted), 0);
    end

    // Mute reversal after 100 down-steps, probed with a known diff
    zeros_to_run();
    cyc(0, 0, 0, 1);
    strobes(100, 2, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 256, 0);
    cyc(0, 0, 0, 0);
    chk("reversal_gain_156", int'(audio_out), 156);
    strobes(99, 2, 0, 0);

    // Fade-out strobe count, then fade-in without counter delay
    cyc(0, 0, 0, 1);
    n = 0;
    while (!muted && n < 300) begin
      cyc(0, 1, 0, 1);
      cyc(0, 0, 0, 1);
      n++;
    end
    chk("fade_out_strobes", n, 256);
    strobes(10, 2, 0, 1);
    cyc(0, 0, 0, 0);
    chk("hold_after_release", int'(muted), 1);
    cyc(0, 1, 0, 0);
    chk("fade_in_first_step", int'(muted), 0);
    strobes(5, 2, 0, 0);

    // DC removal vectors, then monotonic decay
    zeros_to_run();
    foreach (dc_tab[k]) begin
      cyc(0, 1, dc_tab[k].sample, 0);
      cyc(0, 0, dc_tab[k].sample, 0);
      chk("dc_vector", int'(audio_out), dc_tab[k].exp_out);
    end
    prev = int'(audio_out);
    viol = 0;
    first_small = -1;
    for (int i = 5; i < 200; i++) begin
      cyc(0, 1, 16384, 0);
      cyc(0, 0, 16384, 0);
      cur = int'(audio_out);
      if (cur > prev || cur < 0) viol++;
      if (cur <= 16 && first_small < 0) first_small = i;
      prev = cur;
    end
    chk("dc_monotonic_violations", viol, 0);
    chk("dc_settled_within_200", (first_small >= 0 && first_small < 200) ? 1 : 0, 1);

    // Reset mid-ramp at gain 80, together with a strobe that must be dropped
    cyc(1, 0, 0, 0);
    for (int i = 0; i < int'(MC); i++) cyc(0, 0, 0, 0);
    strobes(80, 2, 0, 0);
    cyc(1, 1, 1234, 0);
    chk("midramp_reset_out", int'(audio_out), 0);
    chk("midramp_reset_valid", int'(audio_valid), 0);
    chk("midramp_reset_muted", int'(muted), 1);
    for (int i = 0; i < int'(MC) + 4; i++) begin
      cyc(0, 1, 5000 + i * 100, 0);
      if (i == 0) chk("dropped_sample_valid", int'(audio_valid), 0);
      if (i < int'(MC)) begin
        chk("silence_repeat_out", int'(audio_out), 0);
        chk("silence_repeat_muted", int'(muted), 1);
      end
    end

    // Randomized traffic against the model
    cyc(1, 0, 0, 0);
    begin
      bit m;
      m = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 199) == 0) m = ~m;
        cyc(($urandom_range(0, 1499) == 0), ($urandom_range(0, 2) == 0),
            int'($urandom_range(0, 65535)) - 32768, m);
      end
    end

    // Saturation with a slow DC tracker, back-to-back strobes
    sat_cyc(1, 0, 0);
    sat_cyc(1, 0, 0);
    for (int i = 0; i < 20000; i++) sat_cyc(0, 1, 32767);
    sat_cyc(0, 0, 0);
    chk("sat_settled_small", (s_out <= 16'sd4 && s_out >= -16'sd4) ? 1 : 0, 1);
    chk("sat_in_run", int'(s_muted), 0);
    sat_cyc(0, 1, -32768);
    sat_cyc(0, 0, 0);
    chk("sat_neg_clamp", int'(s_out), -32768);
    chk("sat_neg_valid", int'(s_valid), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
